// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises NLEDS 24-bit 0xRRGGBB words as WS2812 NRZ pulses (G,R,B order, MSB first) and ends each frame with a latch gap.
// Define WS2812_BRIGHTNESS_EN to add the brightness port, which scales each channel when a pixel is loaded.
module ws2812_tx #(
  parameter int NLEDS  = 8,
  parameter int TBIT   = 60,
  parameter int T0H    = 19,
  parameter int T1H    = 38,
  parameter int TRESET = 2880
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] data,
  input  logic        valid,
  output logic        ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underflow
`ifdef WS2812_BRIGHTNESS_EN
  ,
  input  logic [7:0]  brightness
`endif
);

  localparam int CW = $clog2(TBIT);
  localparam int GW = $clog2(TRESET + 1);
  localparam int PW = $clog2(NLEDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_FETCH,
    S_LATCH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    bit_q, bit_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [23:0]   shift_q, shift_d;
  logic          dout_q, dout_d;
  logic          fdone_q, fdone_d;
  logic          uflow_c;
  logic [23:0]   load_val;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * {7'd0, ({1'b0, b} + 9'd1)};
    return 8'(prod >> 8);
  endfunction

  assign load_val = {scale(data[15:8], brightness),
                     scale(data[23:16], brightness),
                     scale(data[7:0], brightness)};
`else
  assign load_val = {data[15:8], data[23:16], data[7:0]};
`endif

  assign ready      = rst && ((state_q == S_IDLE) || (state_q == S_FETCH));
  assign busy       = (state_q != S_IDLE);
  assign dout       = dout_q;
  assign frame_done = fdone_q;
  assign underflow  = uflow_c && rst;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    fdone_d = 1'b0;
    uflow_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        pix_d = '0;
        if (valid) begin
          shift_d = load_val;
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_BIT;
        end
      end

      S_BIT: begin
        // The last bit is one cycle short; the following FETCH/LATCH cycle completes its period.
        if (cyc_q == ((bit_q == 5'd23) ? CW'(TBIT - 2) : CW'(TBIT - 1))) begin
          cyc_d   = '0;
          shift_d = {shift_q[22:0], 1'b0};
          bit_d   = bit_q + 5'd1;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            gap_d = '0;
            if (pix_q == PW'(NLEDS - 1)) begin
              pix_d   = '0;
              state_d = S_LATCH;
            end else begin
              pix_d   = pix_q + PW'(1);
              state_d = S_FETCH;
            end
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      S_FETCH: begin
        if (valid) begin
          shift_d = load_val;
          cyc_d   = '0;
          bit_d   = '0;
          gap_d   = '0;
          state_d = S_BIT;
        end else if (gap_q == GW'(TRESET - 1)) begin
          uflow_c = 1'b1;
          pix_d   = '0;
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_LATCH: begin
        if (gap_q == GW'(TRESET - 1)) begin
          fdone_d = 1'b1;
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // dout is registered from next-state values so the pin is glitch-free without extra latency.
    dout_d = (state_d == S_BIT) &&
             (cyc_d < (shift_d[23] ? CW'(T1H) : CW'(T0H)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      fdone_q <= fdone_d;
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: random pixel frames, underflow and mid-bit reset, checked against a waveform-level model.
// Build with WS2812_BRIGHTNESS_EN defined to exercise the brightness scaler as well.
module tb_ws2812_tx;

  localparam int NLEDS  = 2;
  localparam int TBIT   = 60;
  localparam int T0H    = 19;
  localparam int T1H    = 38;
  localparam int TRESET = 2880;
  localparam int PIXC   = 24 * TBIT;
  localparam int LOGN   = 131072;
`ifdef WS2812_BRIGHTNESS_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [23:0] data;
  logic        valid;
  logic        ready;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underflow;
  logic [7:0]  bright;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic dout_log [0:LOGN-1];
  int xfer_c[$];
  int fd_q[$];
  int uf_q[$];

  ws2812_tx #(
    .NLEDS(NLEDS), .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRESET(TRESET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .valid(valid),
    .ready(ready),
    .dout(dout),
    .busy(busy),
    .frame_done(frame_done),
    .underflow(underflow)
`ifdef WS2812_BRIGHTNESS_EN
    ,
    .brightness(bright)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge; cycle k is the one whose rising edge performs a transfer.
  always @(negedge clk) begin
    if (cyc < LOGN) dout_log[cyc] = dout;
    if (valid && ready) xfer_c.push_back(cyc);
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if (underflow === 1'b1) uf_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] expect_grb(input logic [23:0] w, input logic [7:0] br);
    int r, g, b;
    r = int'(w[23:16]);
    g = int'(w[15:8]);
    b = int'(w[7:0]);
    if (BR_EN) begin
      r = (r * (int'(br) + 1)) / 256;
      g = (g * (int'(br) + 1)) / 256;
      b = (b * (int'(br) + 1)) / 256;
    end
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  function automatic int count_high(input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++)
      if (c < LOGN && dout_log[c] !== 1'b0) n++;
    return n;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    xfer_c.delete();
    fd_q.delete();
    uf_q.delete();
  endtask

  // Offer one pixel and wait (bounded) for the handshake; optionally keep valid high afterwards.
  task automatic send_pixel(input logic [23:0] w, input bit keep_valid);
    int n = 0;
    bit done = 1'b0;
    valid = 1'b1;
    data  = w;
    while (!done) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      else begin
        n++;
        if (n > 3 * PIXC) begin
          check("xfer_timeout", 32'd1, 32'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      valid = 1'b0;
      data  = 24'($urandom);
    end
  endtask

  task automatic check_pixel(input int k, input logic [23:0] w);
    logic [23:0] exp_grb;
    logic [23:0] dec;
    int bad, hi, h, c;
    exp_grb = expect_grb(w, bright);
    dec = '0;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      h  = exp_grb[23 - i] ? T1H : T0H;
      hi = 0;
      for (int j = 0; j < TBIT; j++) begin
        c = k + 1 + i * TBIT + j;
        if (c >= LOGN || dout_log[c] !== 1'(j < h)) bad++;
        if (c < LOGN && dout_log[c] === 1'b1) hi++;
      end
      dec[23 - i] = (hi == T1H);
    end
    check("pix_bits", dec, exp_grb);
    check("pix_wave", bad, 0);
  endtask

  task automatic run_frame(input logic [23:0] w0, input logic [23:0] w1);
    int k0, k1;
    clear_logs();
    send_pixel(w0, 1'b1);
    send_pixel(w1, 1'b0);
    wait_cycles(PIXC + TRESET + 10);
    check("xfer_count", xfer_c.size(), 2);
    if (xfer_c.size() == 2) begin
      k0 = xfer_c[0];
      k1 = xfer_c[1];
      check("xfer_spacing", k1 - k0, PIXC);
      check_pixel(k0, w0);
      check_pixel(k1, w1);
      check("latch_low", count_high(k1 + PIXC, k1 + PIXC + TRESET), 0);
      check("fd_count", fd_q.size(), 1);
      if (fd_q.size() == 1) check("fd_time", fd_q[0], k1 + PIXC + TRESET);
    end
    check("uf_none", uf_q.size(), 0);
  endtask

  initial begin
    int k, r0;
    logic [23:0] w;
    rst    = 1'b0;
    valid  = 1'b1;
    data   = 24'($urandom);
    bright = 8'd255;

    // Reset held with valid offered
    wait_cycles(5);
    check("rst_ready", ready, 1'b0);
    check("rst_dout", dout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_uf", underflow, 1'b0);
    check("rst_noxfer", xfer_c.size() + fd_q.size() + uf_q.size(), 0);
    valid = 1'b0;
    rst   = 1'b1;
    wait_cycles(1);
    check("rel_ready", ready, 1'b1);
    check("rel_busy", busy, 1'b0);

    run_frame(24'hFF0000, 24'($urandom));
    run_frame(24'h0000FF, 24'h00FF00);

    // Underflow: only one pixel of a two-pixel frame arrives
    clear_logs();
    w = 24'($urandom);
    send_pixel(w, 1'b0);
    check("uf_busy", busy, 1'b1);
    wait_cycles(PIXC + TRESET + 10);
    check("uf_xfer", xfer_c.size(), 1);
    if (xfer_c.size() == 1) begin
      k = xfer_c[0];
      check_pixel(k, w);
      check("uf_count", uf_q.size(), 1);
      if (uf_q.size() == 1) check("uf_time", uf_q[0], k + PIXC + TRESET - 1);
      check("uf_low", count_high(k + PIXC, k + PIXC + TRESET), 0);
    end
    check("uf_no_fd", fd_q.size(), 0);
    check("uf_idle", busy, 1'b0);
    // Index must restart at 0: a full two-pixel frame follows
    run_frame(24'($urandom), 24'($urandom));

    bright = 8'd127;
    run_frame(24'hFFFFFF, 24'hFFFFFF);
    bright = 8'($urandom);
    run_frame(24'($urandom), 24'($urandom));

    // Reset for one cycle during the high phase of the first bit
    clear_logs();
    send_pixel(24'($urandom), 1'b1);
    wait_cycles(3);
    check("mid_busy", busy, 1'b1);
    check("mid_high", dout, 1'b1);
    valid = 1'b0;
    rst = 1'b0;
    wait_cycles(1);
    rst = 1'b1;
    r0 = cyc;
    check("mid_dout", dout, 1'b0);
    check("mid_idle", busy, 1'b0);
    wait_cycles(2 * PIXC + TRESET + 10);
    check("mid_quiet", count_high(r0, cyc - 1), 0);
    check("mid_no_fd", fd_q.size(), 0);
    check("mid_no_uf", uf_q.size(), 0);

    bright = 8'd255;
    run_frame(24'hFFFFFF, 24'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
